seq_divider: RTL

- Multi-cycle restoring integer divider: the subtract-and-shift counterpart to the ALU's carry-chain adder.
- Accepts one dividend/divisor pair over a valid/ready handshake and computes one quotient bit per clock.
- Returns quotient and remainder over a second valid/ready handshake.
- Sits beside the adder in the UART-driven ALU datapath and serves DIV/REM opcodes, signed and unsigned.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/seq_divider_div_step.sv | 24 ++
 rtl/seq_divider.sv | 116 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath types for the sequential divider: FSM states, counter sizing
// and the registered result bundle.
package alu_pkg;

  // Operand width the result struct is built for; seq_divider's width_p must match it.
  localparam int unsigned div_width_lp = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_e;

  // Iteration counter width: enough bits to count steps 0 .. width-1.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

  typedef struct packed {
    logic [div_width_lp-1:0] quotient;
    logic [div_width_lp-1:0] remainder;
    logic                    dbz;
  } div_result_s;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when no borrow occurs.
module div_step #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] rem_i,
  input  logic               dividend_msb_i,
  input  logic [width_p-1:0] divisor_i,
  output logic [width_p-1:0] next_rem_o,
  output logic               q_bit_o
);

  logic [width_p:0] w_partial;
  logic [width_p:0] w_diff_lo;

  assign w_partial = {rem_i, dividend_msb_i};

  // A set top bit of the partial remainder always covers the divisor, so only the
  // low width_p bits need the subtractor; the difference wraps to the right value.
  assign w_diff_lo  = {1'b0, w_partial[width_p-1:0]} - {1'b0, divisor_i};
  assign q_bit_o    = w_partial[width_p] | ~w_diff_lo[width_p];
  assign next_rem_o = q_bit_o ? w_diff_lo[width_p-1:0] : w_partial[width_p-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, signed/unsigned, one quotient bit per clock with
// valid/ready handshakes on both the operand and result sides.
module seq_divider
  import alu_pkg::*;
#(
  parameter int width_p = div_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               signed_i,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               div_by_zero_o
);

  localparam int unsigned       cnt_w_lp    = div_cnt_w(width_p);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

  div_state_e          r_state, w_state_nxt;
  logic [width_p-1:0]  r_dvd_q;
  logic [width_p-1:0]  r_rem;
  logic [width_p-1:0]  r_dvs;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                r_q_neg, r_r_neg;
  div_result_s         r_result;

  logic                w_accept, w_last, w_q_bit;
  logic                w_dvd_neg, w_dvs_neg;
  logic [width_p-1:0]  w_dvd_mag, w_dvs_mag, w_q_mag, w_rem_nxt;

  assign ready_o   = (r_state == IDLE);
  assign valid_o   = (r_state == DONE);
  assign w_accept  = valid_i & ready_o;
  assign w_last    = (r_cnt == last_cnt_lp);

  assign w_dvd_neg = signed_i & dividend_i[width_p-1];
  assign w_dvs_neg = signed_i & divisor_i[width_p-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend_i : dividend_i;
  assign w_dvs_mag = w_dvs_neg ? -divisor_i : divisor_i;

  // r_dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  assign w_q_mag   = {r_dvd_q[width_p-2:0], w_q_bit};

  div_step #(.width_p(width_p)) u_step (
    .rem_i          (r_rem),
    .dividend_msb_i (r_dvd_q[width_p-1]),
    .divisor_i      (r_dvs),
    .next_rem_o     (w_rem_nxt),
    .q_bit_o        (w_q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first means every path drives w_state_nxt, so no latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (divisor_i == '0) ? DONE : BUSY;
      BUSY:    if (w_last)   w_state_nxt = DONE;
      DONE:    if (ready_i)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_dvd_q  <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_dvd_q <= w_dvd_mag;
          r_dvs   <= w_dvs_mag;
          r_rem   <= '0;
          r_cnt   <= '0;
          r_q_neg <= w_dvd_neg ^ w_dvs_neg;
          r_r_neg <= w_dvd_neg;
          if (divisor_i == '0)
            r_result <= '{quotient: '1, remainder: dividend_i, dbz: 1'b1};
        end
        BUSY: begin
          r_dvd_q <= w_q_mag;
          r_rem   <= w_rem_nxt;
          r_cnt   <= r_cnt + 1'b1;
          // MIN / -1 falls out naturally: magnitude 2^(w-1) with a positive sign is MIN.
          if (w_last)
            r_result <= '{quotient:  r_q_neg ? -w_q_mag : w_q_mag,
                          remainder: r_r_neg ? -w_rem_nxt : w_rem_nxt,
                          dbz:       1'b0};
        end
        default: ;
      endcase
    end
  end

  assign quotient_o    = r_result.quotient;
  assign remainder_o   = r_result.remainder;
  assign div_by_zero_o = r_result.dbz;

endmodule
